// File: rtl/spdif_pkg.sv
// Shared constants for the S/PDIF subframe path: preamble codes,
// block length and bit offsets inside the 28-bit subframe field.
package spdif_pkg;

   localparam logic [1:0] PRE_B = 2'd0;
   localparam logic [1:0] PRE_M = 2'd1;
   localparam logic [1:0] PRE_W = 2'd2;

   localparam int FRAMES_PER_BLOCK = 192;

   localparam int AUDIO_LSB = 0;
   localparam int V_BIT     = 24;
   localparam int U_BIT     = 25;
   localparam int C_BIT     = 26;
   localparam int P_BIT     = 27;

endpackage

// File: rtl/spdif_subframe_pack.sv
// Packs audio/V/U/C into time slots 4..31 and appends even parity.
// Ports: audio[23:0], v, u, c in; subframe[27:0] out (combinational).
module spdif_subframe_pack
   import spdif_pkg::*;
(
   input  logic [23:0] audio,
   input  logic        v,
   input  logic        u,
   input  logic        c,
   output logic [27:0] subframe
);

   logic [27:0] sf;

   always_comb begin
      sf = '0;
      sf[AUDIO_LSB +: 24] = audio;
      sf[V_BIT] = v;
      sf[U_BIT] = u;
      sf[C_BIT] = c;
      // parity makes slots 4..31 carry an even number of ones
      sf[P_BIT] = ^sf[P_BIT-1:0];
      subframe = sf;
   end

endmodule

// File: rtl/spdif_subframe_sequencer.sv
// Sequences stereo pairs into left/right IEC 60958 subframes with
// block tracking and per-frame channel status bit.
// Ports: clk, reset; channelStatus[191:0]; inValid/inReady with
// inLeft, inRight, inInvalid; outValid/outReady with outPreamble,
// outSubframe[27:0], outFrameIndex[7:0].
module spdif_subframe_sequencer
   import spdif_pkg::*;
#(
   parameter int SAMPLE_WIDTH = 24
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [191:0]            channelStatus,
   input  logic                    inValid,
   output logic                    inReady,
   input  logic [SAMPLE_WIDTH-1:0] inLeft,
   input  logic [SAMPLE_WIDTH-1:0] inRight,
   input  logic                    inInvalid,
   output logic                    outValid,
   input  logic                    outReady,
   output logic [1:0]              outPreamble,
   output logic [27:0]             outSubframe,
   output logic [7:0]              outFrameIndex
);

   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_BLOCK - 1);

   logic [SAMPLE_WIDTH-1:0] holdL;
   logic [SAMPLE_WIDTH-1:0] holdR;
   logic                    holdV;
   logic                    loaded;
   logic                    phase;
   logic [7:0]              heldIndex;
   logic [7:0]              pairCount;
   logic [191:0]            csReg;

   logic       accept;
   logic       outFire;
   logic [23:0] audio;
   logic       cBit;

   assign outValid = loaded;
   assign outFire  = loaded && outReady;
   // a new pair may enter while the right subframe leaves
   assign inReady  = !reset && (!loaded || (phase && outReady));
   assign accept   = inValid && inReady;

   always_ff @(posedge clk) begin
      if (reset) begin
         holdL     <= '0;
         holdR     <= '0;
         holdV     <= 1'b0;
         loaded    <= 1'b0;
         phase     <= 1'b0;
         heldIndex <= '0;
         pairCount <= '0;
         csReg     <= '0;
      end else if (accept) begin
         holdL     <= inLeft;
         holdR     <= inRight;
         holdV     <= inInvalid;
         loaded    <= 1'b1;
         phase     <= 1'b0;
         heldIndex <= pairCount;
         pairCount <= (pairCount == LAST_FRAME) ? '0 : pairCount + 8'd1;
         if (pairCount == '0)
            csReg <= channelStatus;
      end else if (outFire) begin
         if (!phase)
            phase <= 1'b1;
         else
            loaded <= 1'b0;
      end
   end

   always_comb begin
      audio = 24'(phase ? holdR : holdL) << (24 - SAMPLE_WIDTH);
      cBit  = csReg[heldIndex];
      outPreamble = PRE_W;
      if (!phase)
         outPreamble = (heldIndex == '0) ? PRE_B : PRE_M;
   end

   assign outFrameIndex = heldIndex;

   spdif_subframe_pack u_pack (
      .audio    (audio),
      .v        (holdV),
      .u        (1'b0),
      .c        (cBit),
      .subframe (outSubframe)
   );

endmodule

// File: tb/tb_spdif_subframe_sequencer.sv
// Bench for spdif_subframe_sequencer: vector table, directed corner
// sequences and random traffic against a queue-based reference.
module tb_spdif_subframe_sequencer;

   logic         clk = 1'b0;
   logic         reset;
   logic [191:0] channelStatus;
   logic         inValid;
   logic         inReady;
   logic [23:0]  inLeft;
   logic [23:0]  inRight;
   logic         inInvalid;
   logic         outValid;
   logic         outReady;
   logic [1:0]   outPreamble;
   logic [27:0]  outSubframe;
   logic [7:0]   outFrameIndex;

   logic         iv16;
   logic         rdy16;
   logic [15:0]  l16;
   logic [15:0]  r16;
   logic         inv16;
   logic         ov16;
   logic [1:0]   pre16;
   logic [27:0]  sf16;
   logic [7:0]   idx16;

   always #5 clk = ~clk;

   spdif_subframe_sequencer #(.SAMPLE_WIDTH(24)) dut (
      .clk           (clk),
      .reset         (reset),
      .channelStatus (channelStatus),
      .inValid       (inValid),
      .inReady       (inReady),
      .inLeft        (inLeft),
      .inRight       (inRight),
      .inInvalid     (inInvalid),
      .outValid      (outValid),
      .outReady      (outReady),
      .outPreamble   (outPreamble),
      .outSubframe   (outSubframe),
      .outFrameIndex (outFrameIndex)
   );

   spdif_subframe_sequencer #(.SAMPLE_WIDTH(16)) dut16 (
      .clk           (clk),
      .reset         (reset),
      .channelStatus (192'h0),
      .inValid       (iv16),
      .inReady       (rdy16),
      .inLeft        (l16),
      .inRight       (r16),
      .inInvalid     (inv16),
      .outValid      (ov16),
      .outReady      (1'b1),
      .outPreamble   (pre16),
      .outSubframe   (sf16),
      .outFrameIndex (idx16)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic check(input string nm,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [1:0]  pre;
      logic [27:0] sf;
      logic [7:0]  idx;
   } exp_t;

   exp_t         q[$];
   int           pairs;
   logic [191:0] csSnap;
   logic [191:0] csDrive;
   int           nCons;
   int           nB;

   function automatic logic [27:0] mk(input logic [23:0] a,
                                      input bit v,
                                      input bit c);
      logic [26:0] b;
      b = {c, 1'b0, v, a};
      return {^b, b};
   endfunction

   task automatic mstep(input bit iv, input logic [23:0] l,
                        input logic [23:0] r, input bit inv,
                        input bit ordy, input bit rst,
                        output bit acc);
      bit   er;
      int   f;
      exp_t e;
      @(negedge clk);
      reset = rst;
      inValid = iv;
      inLeft = l;
      inRight = r;
      inInvalid = inv;
      outReady = ordy;
      channelStatus = csDrive;
      #1;
      acc = 1'b0;
      if (rst) begin
         check("ready_in_reset", 32'(inReady), 32'd0);
         q.delete();
         pairs = 0;
         return;
      end
      er = (q.size() == 0) || (q.size() == 1 && ordy);
      check("inReady", 32'(inReady), 32'(er));
      check("outValid", 32'(outValid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check("preamble", 32'(outPreamble), 32'(q[0].pre));
         check("subframe", 32'(outSubframe), 32'(q[0].sf));
         check("frameIdx", 32'(outFrameIndex), 32'(q[0].idx));
      end
      if (outValid && ordy) begin
         nCons++;
         if (outPreamble == 2'd0) nB++;
      end
      if (q.size() != 0 && ordy) void'(q.pop_front());
      if (iv && er) begin
         acc = 1'b1;
         f = pairs % 192;
         if (f == 0) csSnap = csDrive;
         e.idx = 8'(f);
         e.pre = (f == 0) ? 2'd0 : 2'd1;
         e.sf = mk(l, inv, csSnap[f]);
         q.push_back(e);
         e.pre = 2'd2;
         e.sf = mk(r, inv, csSnap[f]);
         q.push_back(e);
         pairs++;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      bit          iv;
      logic [23:0] l;
      logic [23:0] r;
      bit          ordy;
      bit          ev;
      bit          er;
      logic [1:0]  ep;
      logic [27:0] es;
      logic [7:0]  ei;
      bit          cd;
   } vec_t;

   vec_t tbl[4];

   initial begin
      bit           acc;
      logic [191:0] csOld;
      logic [191:0] csNew;
      logic [23:0]  l;
      logic [23:0]  r;

      tbl[0] = '{1, 24'h1, 24'h3, 1, 0, 1, 2'd0, 28'h0, 8'd0, 1};
      tbl[1] = '{0, 24'h0, 24'h0, 1, 1, 0, 2'd0, 28'h8000001, 8'd0, 1};
      tbl[2] = '{0, 24'h0, 24'h0, 1, 1, 1, 2'd2, 28'h0000003, 8'd0, 1};
      tbl[3] = '{0, 24'h0, 24'h0, 1, 0, 1, 2'd0, 28'h0, 8'd0, 0};

      reset = 1'b1;
      inValid = 1'b0;
      inLeft = '0;
      inRight = '0;
      inInvalid = 1'b0;
      outReady = 1'b1;
      channelStatus = 192'h4;
      iv16 = 1'b0;
      l16 = '0;
      r16 = '0;
      inv16 = 1'b0;
      csDrive = '0;
      csSnap = '0;
      pairs = 0;
      nCons = 0;
      nB = 0;
      repeat (2) @(posedge clk);

      // table: reset state, then the first pair L=1 R=3
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         reset = 1'b0;
         inValid = tbl[i].iv;
         inLeft = tbl[i].l;
         inRight = tbl[i].r;
         outReady = tbl[i].ordy;
         #1;
         check($sformatf("tbl%0d_valid", i), 32'(outValid),
               32'(tbl[i].ev));
         check($sformatf("tbl%0d_ready", i), 32'(inReady),
               32'(tbl[i].er));
         if (tbl[i].cd) begin
            check($sformatf("tbl%0d_pre", i), 32'(outPreamble),
                  32'(tbl[i].ep));
            check($sformatf("tbl%0d_sf", i), 32'(outSubframe),
                  32'(tbl[i].es));
            check($sformatf("tbl%0d_idx", i), 32'(outFrameIndex),
                  32'(tbl[i].ei));
         end
      end

      // 16-bit instance: MSB alignment, V flag, parity
      @(negedge clk);
      iv16 = 1'b1;
      l16 = 16'h8000;
      r16 = 16'h0001;
      inv16 = 1'b1;
      #1;
      check("w16_ready", 32'(rdy16), 32'd1);
      @(negedge clk);
      iv16 = 1'b0;
      #1;
      check("w16_left_sf", 32'(sf16), 32'h1800000);
      check("w16_left_pre", 32'(pre16), 32'd0);
      @(negedge clk);
      #1;
      check("w16_right_sf", 32'(sf16), 32'h1000100);
      check("w16_right_pre", 32'(pre16), 32'd2);

      // full block plus one frame, back-to-back, cs swap at frame 50
      for (int k = 0; k < 192; k++) begin
         csOld[k] = (k % 3 == 0);
      end
      csNew = ~csOld;
      csDrive = csOld;
      mstep(0, 0, 0, 0, 1, 1, acc);
      nCons = 0;
      nB = 0;
      for (int s = 0; s < 387; s++) begin
         l = {8'hA5, 8'(pairs), 8'(pairs * 7)};
         r = {8'h5A, 8'(pairs * 3), 8'(pairs)};
         mstep(pairs < 193, l, r, pairs[0], 1, 0, acc);
         if (pairs == 51) csDrive = csNew;
      end
      check("block_pairs", 32'(pairs), 32'd193);
      check("block_subframes", 32'(nCons), 32'd386);
      check("block_b_count", 32'(nB), 32'd2);

      // stall the left subframe for 5 cycles
      mstep(0, 0, 0, 0, 1, 1, acc);
      mstep(1, 24'h123456, 24'h654321, 0, 1, 0, acc);
      for (int s = 0; s < 5; s++) begin
         mstep(1, 24'hFFFFFF, 24'hEEEEEE, 1, 0, 0, acc);
      end
      for (int s = 0; s < 3; s++) begin
         mstep(0, 0, 0, 0, 1, 0, acc);
      end

      // reset right after the left subframe of frame 7
      mstep(0, 0, 0, 0, 1, 1, acc);
      while (pairs < 8) begin
         mstep(1, 24'(pairs + 100), 24'(pairs + 200), 0, 1, 0, acc);
      end
      mstep(0, 0, 0, 0, 1, 0, acc);
      mstep(0, 0, 0, 0, 0, 1, acc);
      mstep(0, 0, 0, 0, 1, 0, acc);
      mstep(1, 24'h00ABCD, 24'h00DCBA, 0, 1, 0, acc);
      mstep(0, 0, 0, 0, 1, 0, acc);
      mstep(0, 0, 0, 0, 1, 0, acc);

      // random traffic
      mstep(0, 0, 0, 0, 1, 1, acc);
      for (int s = 0; s < 2000; s++) begin
         if ($urandom_range(0, 49) == 0)
            csDrive = {$urandom, $urandom, $urandom,
                       $urandom, $urandom, $urandom};
         mstep($urandom_range(0, 3) != 0, 24'($urandom),
               24'($urandom), 1'($urandom),
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 299) == 0, acc);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
